video_tint_pipe: RTL and testbench
==================================

VIDEO_TINT_PIPE -- requirements
Module: video_tint_pipe

Interface
REQ-001 Parameter CW, default 6: bit width of each colour channel, input and output.
REQ-002 Parameter VS_ACT, default 0: active level of vsync_in.
REQ-003 Parameter HS_ACT, default 0: active level of hsync_in.
REQ-004 clk_vga  input  1: pixel clock; the only clock.
REQ-005 rst_n  input  1: asynchronous, active-low reset.
REQ-006 r_in, g_in, b_in  input  CW each: source colour.
REQ-007 hsync_in, vsync_in, de_in  input  1 each: source syncs and display enable.
REQ-008 mode  input  3: requested tint (0 colour, 1 green, 2 amber, 3 white, 4 blue; 5-7 colour).
REQ-009 scan_on  input  1: scanline dimming request (see Configuration).
REQ-010 r_out, g_out, b_out  output  CW each: tinted colour.
REQ-011 hsync_out, vsync_out, de_out  output  1 each: syncs and enable aligned to the colour outputs.
REQ-012 mode_act  output  3: tint mode currently in effect.

Function
REQ-013 The block shall be a 3-stage pipeline: S1 registers the inputs, S2 registers the weighted products, S3 registers the tinted result; latency from input to output is exactly 3 clk_vga cycles.
REQ-014 hsync, vsync and de shall pass through 3 delay registers so they stay cycle-aligned with the colour outputs.
REQ-015 Luma Y shall be (54*R + 183*G + 19*B) >> 8, with products CW+8 bits wide and the sum CW+10 bits wide, saturated to 2^CW-1.
REQ-016 With full-scale input (R=G=B=2^CW-1), Y shall equal 2^CW-1 and shall not wrap.
REQ-017 Mode 0 and modes 5-7 shall output the S1 colour unchanged.
REQ-018 Mode 1 shall output (0, Y, 0).
REQ-019 Mode 2 shall output (Y, Y>>1, 0).
REQ-020 Mode 3 shall output (Y, Y, Y).
REQ-021 Mode 4 shall output (Y>>1, Y>>1, Y).
REQ-022 When the delayed de is 0, the block shall drive all colour outputs to 0, overriding every mode.
REQ-023 The mode input shall be captured every cycle into a pending register.
REQ-024 mode_act shall load the pending value only on the first cycle in which vsync_in goes from inactive to active, as seen at S1.
REQ-025 A mode change therefore takes effect at a frame boundary, with no mid-frame tearing.
REQ-026 If mode changes in the same cycle as the vsync edge, mode_act shall take the pending value from before that cycle, i.e. the value registered one cycle earlier.
REQ-027 The tint of each pixel shall be chosen by the mode_act value in force when that pixel was in S2.

Reset
REQ-028 While rst_n=0, all pipeline registers, all colour outputs and de_out shall be 0.
REQ-029 While rst_n=0, hsync_out and vsync_out shall sit at their inactive levels (!HS_ACT, !VS_ACT).
REQ-030 While rst_n=0, mode_act, the pending mode and the line-parity bit shall be 0.
REQ-031 Reset asserted mid-frame shall clear all state immediately, with no clock required.
REQ-032 After release, the first valid output shall appear 3 cycles after the first sampled input.
REQ-033 After release, the block shall run in colour mode until the next vsync edge.

Configuration
REQ-034 With macro VIDEO_TINT_SCANLINE_EN defined, a line-parity bit shall toggle on every inactive-to-active edge of hsync at S1.
REQ-035 With VIDEO_TINT_SCANLINE_EN defined, the line-parity bit shall be cleared on every vsync active edge.
REQ-036 With VIDEO_TINT_SCANLINE_EN defined, when scan_on=1 and parity=1, each S3 colour channel c shall become c - (c>>2), in every mode.
REQ-037 With VIDEO_TINT_SCANLINE_EN not defined, scan_on shall be ignored, no parity logic shall be built, and outputs shall match REQ-017 to REQ-022 exactly.

Verification
REQ-038 CW=6, mode 0 held across a vsync edge, input (0x3F,0x20,0x01) with de=1 -> output (0x3F,0x20,0x01) 3 cycles later; syncs delayed by exactly 3 cycles.
REQ-039 mode 3 latched at a vsync edge, input (0x3F,0x3F,0x3F) -> output (0x3F,0x3F,0x3F), with no overflow.
REQ-040 mode 2 latched, input (0,0x3F,0) -> Y=0x2D, output (0x2D,0x16,0).
REQ-041 mode switched 0->1 mid-frame -> output remains colour until the next vsync active edge, then (0,Y,0); mode_act changes on that edge only.
REQ-042 de_in=0 with input 0x3F on all channels in any mode -> output (0,0,0); rst_n pulsed low mid-line -> all outputs 0 and syncs inactive during reset, with no clock edge required.
REQ-043 With VIDEO_TINT_SCANLINE_EN defined, scan_on=1, mode 3, input 0x3F on all channels -> even lines 0x3F, odd lines 0x30; without the macro -> every line 0x3F.

Source files
------------

// File: rtl/video_tint_pipe.sv
// video_tint_pipe: 3-stage luma tint pipeline whose mode changes only at a vsync active edge.
// Optional scanline dimming is built when VIDEO_TINT_SCANLINE_EN is defined.
module video_tint_pipe #(
    parameter int CW     = 6,
    parameter bit VS_ACT = 1'b0,
    parameter bit HS_ACT = 1'b0
) (
    input  logic          clk_vga,
    input  logic          rst_n,
    input  logic [CW-1:0] r_in,
    input  logic [CW-1:0] g_in,
    input  logic [CW-1:0] b_in,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic          de_in,
    input  logic [2:0]    mode,
    input  logic          scan_on,
    output logic [CW-1:0] r_out,
    output logic [CW-1:0] g_out,
    output logic [CW-1:0] b_out,
    output logic          hsync_out,
    output logic          vsync_out,
    output logic          de_out,
    output logic [2:0]    mode_act
);
    logic [CW-1:0] r1_q, g1_q, b1_q, r2_q, g2_q, b2_q, r3_q, g3_q, b3_q;
    logic [CW-1:0] r3_d, g3_d, b3_d, rt, gt, bt, y;
    logic [CW+7:0] pr_q, pg_q, pb_q, pr_d, pg_d, pb_d;
    logic [CW+9:0] y_sum, y_sh;
    logic [2:0]    hs_q, vs_q, de_q;
    logic [2:0]    mode_pend_q, mode_act_q, mode_act_d;
    logic          vs_edge;

    // Edge is the incoming vsync against the S1 copy, so a mode written in
    // the edge cycle itself is still only pending.
    assign vs_edge    = (vsync_in == VS_ACT) && (vs_q[0] != VS_ACT);
    assign mode_act_d = vs_edge ? mode_pend_q : mode_act_q;

    assign pr_d  = (CW+8)'(r1_q) * (CW+8)'(54);
    assign pg_d  = (CW+8)'(g1_q) * (CW+8)'(183);
    assign pb_d  = (CW+8)'(b1_q) * (CW+8)'(19);
    assign y_sum = (CW+10)'(pr_q) + (CW+10)'(pg_q) + (CW+10)'(pb_q);
    assign y_sh  = y_sum >> 8;
    assign y     = |y_sh[CW+9:CW] ? '1 : y_sh[CW-1:0];

`ifdef VIDEO_TINT_SCANLINE_EN
    logic par_q, par_d, hs_edge;
    assign hs_edge = (hsync_in == HS_ACT) && (hs_q[0] != HS_ACT);
    assign par_d   = vs_edge ? 1'b0 : (hs_edge ? ~par_q : par_q);
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) par_q <= 1'b0;
        else        par_q <= par_d;
    end
`else
    logic scan_on_unused;
    assign scan_on_unused = scan_on;
`endif

    always_comb begin
        rt = r2_q;
        gt = g2_q;
        bt = b2_q;
        case (mode_act_q)
            3'd1:    begin rt = '0;     gt = y;      bt = '0; end
            3'd2:    begin rt = y;      gt = y >> 1; bt = '0; end
            3'd3:    begin rt = y;      gt = y;      bt = y;  end
            3'd4:    begin rt = y >> 1; gt = y >> 1; bt = y;  end
            default: ;
        endcase
`ifdef VIDEO_TINT_SCANLINE_EN
        if (scan_on && par_q) begin
            rt = rt - (rt >> 2);
            gt = gt - (gt >> 2);
            bt = bt - (bt >> 2);
        end
`endif
        r3_d = de_q[1] ? rt : '0;
        g3_d = de_q[1] ? gt : '0;
        b3_d = de_q[1] ? bt : '0;
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            {r1_q, g1_q, b1_q} <= '0;
            {r2_q, g2_q, b2_q} <= '0;
            {r3_q, g3_q, b3_q} <= '0;
            {pr_q, pg_q, pb_q} <= '0;
            hs_q               <= {3{~HS_ACT}};
            vs_q               <= {3{~VS_ACT}};
            de_q               <= '0;
            mode_pend_q        <= '0;
            mode_act_q         <= '0;
        end else begin
            {r1_q, g1_q, b1_q} <= {r_in, g_in, b_in};
            {r2_q, g2_q, b2_q} <= {r1_q, g1_q, b1_q};
            {r3_q, g3_q, b3_q} <= {r3_d, g3_d, b3_d};
            {pr_q, pg_q, pb_q} <= {pr_d, pg_d, pb_d};
            hs_q               <= {hs_q[1:0], hsync_in};
            vs_q               <= {vs_q[1:0], vsync_in};
            de_q               <= {de_q[1:0], de_in};
            mode_pend_q        <= mode;
            mode_act_q         <= mode_act_d;
        end
    end

    assign r_out     = r3_q;
    assign g_out     = g3_q;
    assign b_out     = b3_q;
    assign hsync_out = hs_q[2];
    assign vsync_out = vs_q[2];
    assign de_out    = de_q[2];
    assign mode_act  = mode_act_q;
endmodule

// File: tb/tb_video_tint_pipe.sv
// tb_video_tint_pipe: directed tint vector table plus hand sequences for
// reset, latency, sync delay, frame-boundary mode switch and scanlines.
module tb_video_tint_pipe;
    localparam int CW = 6;
`ifdef VIDEO_TINT_SCANLINE_EN
    localparam logic [CW-1:0] ODD = 6'h30;
`else
    localparam logic [CW-1:0] ODD = 6'h3F;
`endif

    logic          clk_vga = 1'b0;
    logic          rst_n;
    logic [CW-1:0] r_in, g_in, b_in, r_out, g_out, b_out;
    logic          hsync_in, vsync_in, de_in, scan_on;
    logic          hsync_out, vsync_out, de_out;
    logic [2:0]    mode, mode_act;
    int            n_run = 0;
    int            n_fail = 0;

    always #5 clk_vga = ~clk_vga;

    video_tint_pipe #(.CW(CW), .VS_ACT(1'b0), .HS_ACT(1'b0)) dut (
        .clk_vga(clk_vga), .rst_n(rst_n),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
        .mode(mode), .scan_on(scan_on),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out),
        .mode_act(mode_act)
    );

    typedef struct packed {
        logic [2:0]    m;
        logic          de;
        logic [CW-1:0] r, g, b, er, eg, eb;
    } vec_t;
    vec_t tv [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rgb(input string name, input logic [CW-1:0] r, input logic [CW-1:0] g, input logic [CW-1:0] b);
        chk(name, {r_out, g_out, b_out}, {r, g, b});
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_vga);
    endtask

    task automatic pix(input logic [CW-1:0] r, input logic [CW-1:0] g, input logic [CW-1:0] b, input logic de);
        r_in = r; g_in = g; b_in = b; de_in = de;
    endtask

    task automatic vs_pulse();
        vsync_in = 1'b0;
        tick(1);
        vsync_in = 1'b1;
        tick(1);
    endtask

    initial begin
        tv[0]  = '{3'd0, 1'b1, 6'h3F, 6'h20, 6'h01, 6'h3F, 6'h20, 6'h01};
        tv[1]  = '{3'd3, 1'b1, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F};
        tv[2]  = '{3'd2, 1'b1, 6'h00, 6'h3F, 6'h00, 6'h2D, 6'h16, 6'h00};
        tv[3]  = '{3'd1, 1'b1, 6'h3F, 6'h20, 6'h01, 6'h00, 6'h24, 6'h00};
        tv[4]  = '{3'd4, 1'b1, 6'h3F, 6'h3F, 6'h3F, 6'h1F, 6'h1F, 6'h3F};
        tv[5]  = '{3'd4, 1'b1, 6'h10, 6'h20, 6'h30, 6'h0E, 6'h0E, 6'h1D};
        tv[6]  = '{3'd5, 1'b1, 6'h10, 6'h20, 6'h30, 6'h10, 6'h20, 6'h30};
        tv[7]  = '{3'd3, 1'b0, 6'h3F, 6'h3F, 6'h3F, 6'h00, 6'h00, 6'h00};
        tv[8]  = '{3'd2, 1'b1, 6'h3F, 6'h00, 6'h00, 6'h0D, 6'h06, 6'h00};
        tv[9]  = '{3'd7, 1'b1, 6'h01, 6'h02, 6'h03, 6'h01, 6'h02, 6'h03};
        tv[10] = '{3'd1, 1'b1, 6'h00, 6'h00, 6'h3F, 6'h00, 6'h04, 6'h00};
        tv[11] = '{3'd0, 1'b0, 6'h3F, 6'h3F, 6'h3F, 6'h00, 6'h00, 6'h00};

        rst_n = 1'b1;
        pix(0, 0, 0, 1'b0);
        hsync_in = 1'b1; vsync_in = 1'b1; mode = 3'd3; scan_on = 1'b0;
        #1 rst_n = 1'b0;
        tick(2);
        chk_rgb("reset_rgb", 0, 0, 0);
        chk("reset_de", de_out, 1'b0);
        chk("reset_hs", hsync_out, 1'b1);
        chk("reset_vs", vsync_out, 1'b1);
        chk("reset_mode_act", mode_act, 3'd0);

        rst_n = 1'b1;
        pix(6'h3F, 6'h20, 6'h01, 1'b1);
        tick(2);
        chk("latency_de_early", de_out, 1'b0);
        tick(1);
        chk("latency_de", de_out, 1'b1);
        chk_rgb("post_reset_colour", 6'h3F, 6'h20, 6'h01);
        chk("post_reset_mode_act", mode_act, 3'd0);

        hsync_in = 1'b0;
        tick(1);
        hsync_in = 1'b1;
        tick(1);
        chk("hs_delay2", hsync_out, 1'b1);
        tick(1);
        chk("hs_delay3", hsync_out, 1'b0);
        tick(1);
        chk("hs_delay4", hsync_out, 1'b1);

        vsync_in = 1'b0;
        tick(1);
        chk("vs_latch_mode", mode_act, 3'd3);
        vsync_in = 1'b1;
        tick(1);
        chk("vs_delay2", vsync_out, 1'b1);
        tick(1);
        chk("vs_delay3", vsync_out, 1'b0);
        tick(1);
        chk("vs_delay4", vsync_out, 1'b1);
        chk_rgb("white_after_vs", 6'h24, 6'h24, 6'h24);

        for (int i = 0; i < 12; i++) begin
            mode = tv[i].m;
            tick(1);
            vs_pulse();
            pix(tv[i].r, tv[i].g, tv[i].b, tv[i].de);
            tick(3);
            chk_rgb($sformatf("vec%0d_rgb", i), tv[i].er, tv[i].eg, tv[i].eb);
            chk($sformatf("vec%0d_de", i), de_out, tv[i].de);
            chk($sformatf("vec%0d_mode_act", i), mode_act, tv[i].m);
        end

        mode = 3'd0;
        tick(1);
        vs_pulse();
        pix(6'h3F, 6'h20, 6'h01, 1'b1);
        tick(3);
        mode = 3'd1;
        tick(5);
        chk_rgb("midframe_still_colour", 6'h3F, 6'h20, 6'h01);
        chk("midframe_mode_act", mode_act, 3'd0);
        vsync_in = 1'b0;
        tick(1);
        chk("edge_mode_act", mode_act, 3'd1);
        vsync_in = 1'b1;
        tick(3);
        chk_rgb("after_edge_green", 6'h00, 6'h24, 6'h00);

        mode = 3'd3;
        tick(2);
        vsync_in = 1'b0;
        mode = 3'd4;
        tick(1);
        chk("same_cycle_old_pending", mode_act, 3'd3);
        vsync_in = 1'b1;
        tick(3);
        chk_rgb("same_cycle_white", 6'h24, 6'h24, 6'h24);
        vs_pulse();
        chk("next_frame_blue", mode_act, 3'd4);
        tick(3);
        chk_rgb("blue_rgb", 6'h12, 6'h12, 6'h24);

        mode = 3'd3;
        tick(1);
        vs_pulse();
        pix(6'h3F, 6'h3F, 6'h3F, 1'b1);
        scan_on = 1'b1;
        tick(4);
        chk_rgb("scan_line0", 6'h3F, 6'h3F, 6'h3F);
        for (int l = 1; l < 3; l++) begin
            hsync_in = 1'b0; de_in = 1'b0;
            tick(1);
            hsync_in = 1'b1; de_in = 1'b1;
            tick(4);
            if (l == 1) chk_rgb("scan_line1", ODD, ODD, ODD);
            else        chk_rgb("scan_line2", 6'h3F, 6'h3F, 6'h3F);
        end

        pix(6'h10, 6'h20, 6'h30, 1'b1);
        tick(4);
        #2 rst_n = 1'b0;
        #1;
        chk_rgb("async_rst_rgb", 0, 0, 0);
        chk("async_rst_de", de_out, 1'b0);
        chk("async_rst_hs", hsync_out, 1'b1);
        chk("async_rst_vs", vsync_out, 1'b1);
        chk("async_rst_mode_act", mode_act, 3'd0);
        tick(1);
        rst_n = 1'b1;
        tick(4);
        chk_rgb("rst_release_colour", 6'h10, 6'h20, 6'h30);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
